pwm_gen: RTL and testbench
==========================

# pwm_gen

Counter-driven PWM generator that consumes a free-running count and turns it into a duty-cycled output. It holds an internal WIDTH-bit period counter and double-buffers its duty and period settings, so writes never glitch a period in progress. Start and stop are controlled by a small FSM that always completes the current period cleanly. It sits directly downstream of the team's 4-bit counters and drives LED/motor-style outputs.

## Interface
- WIDTH, 4, width of count, duty and period values
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset; dominates every other input
- en  in  1  run request, level-sensitive, sampled every cycle
- duty_wr  in  1  write strobe for duty shadow register
- duty_in  in  WIDTH  duty value, number of high cycles per period
- period_wr  in  1  write strobe for period shadow register
- period_in  in  WIDTH  period value; period length = period_in+1 cycles
- pwm  out  1  PWM output
- cnt  out  WIDTH  current position within period
- period_end  out  1  high during the last cycle of each running period
- busy  out  1  high whenever state is not IDLE

## Operation
- Registers: duty_sh and period_sh are the shadows; duty_act and period_act are the active copies; cnt; and the 2-bit state (IDLE, RUN, STOPPING).
- Shadow writes: duty_wr or period_wr loads the shadow at the clock edge, in any state. Each strobe is independent of the other.
- Load event: active registers copy the shadows on two occasions: on the IDLE->RUN transition, and at every period boundary in RUN.
  - Bypass: if a write strobe is high in the same cycle as a load event, the active register takes the incoming *_in value.
- FSM transitions:
  - IDLE: cnt held at 0. en=1 -> RUN, with a load event.
  - RUN: cnt increments each cycle. When cnt==period_act, cnt->0 and a load event occurs. en=0 -> STOPPING; cnt keeps counting.
  - STOPPING: cnt keeps counting. en=1 -> RUN; no load event and no cnt disturbance. When cnt==period_act with en=0 -> IDLE and cnt->0.
  - If en=1 in the last cycle of a STOPPING period: go to RUN, cnt->0, and a load event occurs.
- Decoded outputs (combinational from registered state):
  - pwm = busy && (cnt < duty_act), compared unsigned.
  - duty_act > period_act gives 100% duty.
  - duty_act = 0 gives constant 0.
  - period_end = busy && (cnt == period_act).
  - busy = (state != IDLE).
- Reset values: state IDLE, cnt 0, duty_sh 0, duty_act 0, period_sh 2^WIDTH-1, period_act 2^WIDTH-1. Therefore pwm=0, period_end=0, busy=0.

## Timing
- Start latency: en sampled high at edge N puts busy=1 and cnt=0 from edge N. pwm is high in that first cycle if duty_act>0.
- Period: period_act+1 cycles, with cnt running 0..period_act. pwm is high for min(duty_act, period_act+1) cycles at the start of each period.
- Wrap: cnt never exceeds period_act. When period_act = 2^WIDTH-1, cnt wraps naturally from all-ones to 0.
- period_act = 0: cnt stays 0, period_end is high every running cycle, and pwm = (duty_act != 0).
- Shadow writes take effect at the first cycle of the next period, never mid-period. The only exception is the bypass on a load cycle.
- Stop latency: busy falls at the edge after the last cycle of the period in which en went low. Minimum stop latency is 1 cycle; maximum is period_act+1 cycles.
- Reset mid-operation: at the edge where rst=1, all registers take their reset values and pwm drops in that cycle. Any pending writes are discarded.

## Test plan
- Basic run: write period=3 and duty=1, raise en. Required: pwm pattern 1,0,0,0 repeating; cnt 0,1,2,3; period_end high when cnt=3; busy=1.
- Mid-period update: while running period=3, duty=1, write duty=3 at cnt=1. Required: the rest of the current period still shows duty 1. The next period shows pwm 1,1,1,0.
- Graceful stop: with period=7, duty=4, drop en at cnt=2. Required: count continues to 7 with pwm following duty 4. busy, pwm and cnt are all 0 on the following edge.
- Extremes: duty=0 gives pwm constant 0. duty=9 with period=5 gives pwm constant 1. period=0 with duty=1 gives pwm=1 and period_end=1 every cycle.
- Start with bypass: from IDLE, assert en together with duty_wr (duty_in=2) and period_wr (period_in=4). Required: the first period is already 5 cycles long with pwm 1,1,0,0,0.
- Reset mid-run: assert rst at cnt=2 while running. Required: busy=0 and cnt=0 next cycle. After restart with en and no writes, period is 16 cycles and pwm stays 0 (duty 0).

Source files
------------

// File: rtl/pwm_gen_if.sv
// Control and status bundle between a PWM generator and whatever drives it.
interface pwm_gen_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             duty_wr;
    logic [WIDTH-1:0] duty_in;
    logic             period_wr;
    logic [WIDTH-1:0] period_in;
    logic             pwm;
    logic [WIDTH-1:0] cnt;
    logic             period_end;
    logic             busy;

    // Controller side: issues run requests and settings, observes the output.
    modport master (
        output en, duty_wr, duty_in, period_wr, period_in,
        input  pwm, cnt, period_end, busy
    );

    // Generator side.
    modport slave (
        input  en, duty_wr, duty_in, period_wr, period_in,
        output pwm, cnt, period_end, busy
    );
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator with a start/stop FSM that always finishes
// the period in progress before going idle.
module pwm_gen #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pwm_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic             load;
    logic             at_end;
    logic             busy_o;

    assign at_end = (cnt_q == period_act_q);

    // State register: every flop, synchronous reset dominating all inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            duty_sh_q    <= '0;
            period_sh_q  <= '1;
            duty_act_q   <= '0;
            period_act_q <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            duty_sh_q    <= duty_sh_d;
            period_sh_q  <= period_sh_d;
            duty_act_q   <= duty_act_d;
            period_act_q <= period_act_d;
        end
    end

    // Next-state logic: FSM transitions, period counter and load events.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (bus.en) load    = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (!bus.en) state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (bus.en) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Resuming mid-period leaves the count and settings alone.
                    cnt_d = cnt_q + WIDTH'(1);
                    if (bus.en) state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Settings path: shadows take writes any time; active copies only on a
    // load event, picking up a same-cycle write through the shadow's next value.
    always_comb begin
        duty_sh_d    = bus.duty_wr   ? bus.duty_in   : duty_sh_q;
        period_sh_d  = bus.period_wr ? bus.period_in : period_sh_q;
        duty_act_d   = load ? duty_sh_d   : duty_act_q;
        period_act_d = load ? period_sh_d : period_act_q;
    end

    // Output decode from registered state only.
    always_comb begin
        busy_o         = (state_q != IDLE);
        bus.busy       = busy_o;
        bus.cnt        = cnt_q;
        bus.pwm        = busy_o && (cnt_q < duty_act_q);
        bus.period_end = busy_o && at_end;
    end
endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: a vector table for the steady-state behaviour
// plus hand-written sequences for start, stop, resume and reset corners.
module tb_pwm_gen;
    localparam int WIDTH = 4;

    typedef struct {
        logic             rst;
        logic             en;
        logic             dwr;
        logic [WIDTH-1:0] din;
        logic             pwr;
        logic [WIDTH-1:0] pin;
        logic             pwm;
        logic [WIDTH-1:0] cnt;
        logic             pe;
        logic             busy;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    pwm_gen_if #(.WIDTH(WIDTH)) bus ();

    pwm_gen #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl [34];

    function automatic vec_t mk(input logic r, input logic e, input logic dw,
                                input logic [WIDTH-1:0] di, input logic pw,
                                input logic [WIDTH-1:0] pi, input logic p,
                                input logic [WIDTH-1:0] c, input logic pe,
                                input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.dwr = dw; v.din = di; v.pwr = pw; v.pin = pi;
        v.pwm = p; v.cnt = c; v.pe = pe; v.busy = b;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input logic r, input logic e, input logic dw,
                        input logic [WIDTH-1:0] di, input logic pw,
                        input logic [WIDTH-1:0] pi);
        rst           = r;
        bus.en        = e;
        bus.duty_wr   = dw;
        bus.duty_in   = di;
        bus.period_wr = pw;
        bus.period_in = pi;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: pwm,period_end,busy,cnt got %b,%b,%b,%0d required %b,%b,%b,%0d",
                     name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic exp_out(input string name, input logic p, input logic [WIDTH-1:0] c,
                           input logic pe, input logic b);
        check(name, {bus.pwm, bus.period_end, bus.busy, bus.cnt}, {p, pe, b, c});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //            rst en dw din pw pin | pwm cnt pe busy
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0); // reset
        tbl[1]  = mk(0, 0, 1, 1, 1, 3,   0, 0, 0, 0); // write shadows in IDLE
        tbl[2]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 1); // start: period 3 duty 1
        tbl[3]  = mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0,   0, 2, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0,   0, 3, 1, 1);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
        tbl[8]  = mk(0, 1, 1, 3, 0, 0,   0, 2, 0, 1); // duty=3 written mid-period
        tbl[9]  = mk(0, 1, 0, 0, 0, 0,   0, 3, 1, 1);
        tbl[10] = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 1); // new duty from here
        tbl[11] = mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 1);
        tbl[12] = mk(0, 1, 0, 0, 0, 0,   1, 2, 0, 1);
        tbl[13] = mk(0, 1, 0, 0, 0, 0,   0, 3, 1, 1);
        tbl[14] = mk(0, 1, 1, 0, 0, 0,   0, 0, 0, 1); // duty=0 bypassed at boundary
        tbl[15] = mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, 0, 0,   0, 2, 0, 1);
        tbl[17] = mk(0, 1, 0, 0, 0, 0,   0, 3, 1, 1);
        tbl[18] = mk(0, 1, 1, 9, 1, 5,   1, 0, 0, 1); // duty 9 > period 5
        tbl[19] = mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 1);
        tbl[20] = mk(0, 1, 0, 0, 0, 0,   1, 2, 0, 1);
        tbl[21] = mk(0, 1, 0, 0, 0, 0,   1, 3, 0, 1);
        tbl[22] = mk(0, 1, 0, 0, 0, 0,   1, 4, 0, 1);
        tbl[23] = mk(0, 1, 0, 0, 0, 0,   1, 5, 1, 1);
        tbl[24] = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 1);
        tbl[25] = mk(0, 1, 1, 1, 1, 0,   1, 1, 0, 1); // queue period 0 duty 1
        tbl[26] = mk(0, 1, 0, 0, 0, 0,   1, 2, 0, 1);
        tbl[27] = mk(0, 1, 0, 0, 0, 0,   1, 3, 0, 1);
        tbl[28] = mk(0, 1, 0, 0, 0, 0,   1, 4, 0, 1);
        tbl[29] = mk(0, 1, 0, 0, 0, 0,   1, 5, 1, 1);
        tbl[30] = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 1); // period 0: end every cycle
        tbl[31] = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 1);
        tbl[32] = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 1);
        tbl[33] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // stop after 1 cycle

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].dwr, tbl[i].din, tbl[i].pwr, tbl[i].pin);
            exp_out($sformatf("vec%0d", i), tbl[i].pwm, tbl[i].cnt, tbl[i].pe, tbl[i].busy);
        end

        // Start with bypass: first period is already 5 cycles, pwm 1,1,0,0,0.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(0, 1, 1, 2, 1, 4);
            else        step(0, 1, 0, 0, 0, 0);
            exp_out($sformatf("bypass_start%0d", i), i < 2, WIDTH'(i), i == 4, 1'b1);
        end

        // Graceful stop: period 7 duty 4 loaded at the boundary, en drops at cnt 2.
        step(0, 1, 1, 4, 1, 7);
        exp_out("stop_load", 1'b1, 4'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step(0, i <= 2, 0, 0, 0, 0);
            exp_out($sformatf("stop_cnt%0d", i), i < 4, WIDTH'(i), i == 7, 1'b1);
        end
        step(0, 0, 0, 0, 0, 0);
        exp_out("stop_idle", 1'b0, 4'd0, 1'b0, 1'b0);

        // Resume from STOPPING mid-period without disturbing the count, then
        // re-raise en in the last STOPPING cycle so a load picks up duty 6.
        step(0, 1, 0, 0, 0, 0);
        exp_out("resume_start", 1'b1, 4'd0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        exp_out("resume_stopping", 1'b1, 4'd1, 1'b0, 1'b1);
        step(0, 1, 0, 0, 0, 0);
        exp_out("resume_run", 1'b1, 4'd2, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        exp_out("restop", 1'b1, 4'd3, 1'b0, 1'b1);
        step(0, 0, 1, 6, 0, 0);
        exp_out("restop_write", 1'b0, 4'd4, 1'b0, 1'b1);
        for (int i = 5; i <= 7; i++) begin
            step(0, 0, 0, 0, 0, 0);
            exp_out($sformatf("restop_cnt%0d", i), 1'b0, WIDTH'(i), i == 7, 1'b1);
        end
        step(0, 1, 0, 0, 0, 0);
        exp_out("late_restart", 1'b1, 4'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            exp_out($sformatf("duty6_cnt%0d", i), (i % 8) < 6, WIDTH'(i % 8), (i % 8) == 7, 1'b1);
        end

        // Reset mid-run at cnt 2 with a pending write that must be discarded.
        step(1, 1, 1, 5, 1, 2);
        exp_out("midrun_reset", 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            step(0, 1, 0, 0, 0, 0);
            exp_out($sformatf("post_reset%0d", i), 1'b0, WIDTH'(i % 16), i == 15, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
